// File: rtl/burst_ram_if.sv
// burst_ram_if: request, write-beat and read-beat channels of the burst RAM
interface burst_ram_if #(
   parameter int ADDR_WIDTH  = 10,
   parameter int DATA_WIDTH  = 32,
   parameter int BURST_WIDTH = 4
);
   logic                      req_valid;
   logic                      req_ready;
   logic                      req_write;
   logic [ADDR_WIDTH-1:0]     req_addr;
   logic [BURST_WIDTH-1:0]    req_len;
   logic                      req_err;
   logic [DATA_WIDTH-1:0]     wdata;
   logic [DATA_WIDTH/8-1:0]   wstrb;
   logic                      wvalid;
   logic                      wready;
   logic [DATA_WIDTH-1:0]     rdata;
   logic                      rvalid;
   logic                      rready;
   logic                      busy;
   modport master (
      output req_valid, req_write, req_addr, req_len, wdata, wstrb, wvalid, rready,
      input  req_ready, req_err, wready, rdata, rvalid, busy
   );
   modport slave (
      input  req_valid, req_write, req_addr, req_len, wdata, wstrb, wvalid, rready,
      output req_ready, req_err, wready, rdata, rvalid, busy
   );
endinterface

// File: rtl/burst_ram.sv
// burst_ram: single-clock RAM with valid/ready bursts, byte strobes, address wrap
// and a back-pressurable registered read channel.
module burst_ram #(
   parameter int ADDR_WIDTH  = 10,
   parameter int DATA_WIDTH  = 32,
   parameter int LENGTH      = 1 << ADDR_WIDTH,
   parameter int BURST_WIDTH = 4
) (
   input logic       clk,
   input logic       rst,
   burst_ram_if.slave bus
);
   localparam int NB = DATA_WIDTH / 8;
   localparam logic [ADDR_WIDTH:0]   LEN  = (ADDR_WIDTH + 1)'(LENGTH);
   localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(LENGTH - 1);
   typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;
   state_t                 state;
   logic [ADDR_WIDTH-1:0]  addr;
   logic [ADDR_WIDTH-1:0]  nxt;
   logic [BURST_WIDTH-1:0] cnt;
   logic [DATA_WIDTH-1:0]  mem [LENGTH];
   logic                   issue;
   logic                   beat;
   logic                   bad;
   logic                   take;
   always_comb begin
      issue = state == READ && (!bus.rvalid || bus.rready);
      beat  = (state == WRITE && bus.wvalid) || issue;
      bad   = {1'b0, bus.req_addr} >= LEN;
      take  = state == IDLE && bus.req_valid;
      nxt   = addr == LAST ? '0 : addr + 1'b1;
   end
   assign bus.req_ready = state == IDLE;
   assign bus.busy      = state != IDLE;
   assign bus.wready    = state == WRITE;
   // memory array carries no reset so it maps onto block RAM
   always_ff @(posedge clk) begin
      if (state == WRITE && bus.wvalid)
         for (int i = 0; i < NB; i++)
            if (bus.wstrb[i]) mem[addr][8*i +: 8] <= bus.wdata[8*i +: 8];
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         addr        <= '0;
         cnt         <= '0;
         bus.rvalid  <= 1'b0;
         bus.rdata   <= '0;
         bus.req_err <= 1'b0;
      end else begin
         bus.req_err <= take && bad;
         if (issue) begin
            bus.rdata  <= mem[addr];
            bus.rvalid <= 1'b1;
         end else if (bus.rready) bus.rvalid <= 1'b0;
         if (take && !bad) begin
            addr  <= bus.req_addr;
            cnt   <= bus.req_len;
            state <= bus.req_write ? WRITE : READ;
         end else if (beat) begin
            addr <= nxt;
            cnt  <= cnt - 1'b1;
            if (cnt == '0) state <= IDLE;
         end
      end
   end
endmodule

// File: doc/burst_ram.md
# burst_ram

Parametrised single-clock synchronous RAM with a valid/ready request port, byte-lane write strobes, multi-beat bursts with address auto-increment and wrap, and a back-pressurable registered read channel. It replaces the bare chip-select/tristate RAM used by the CPU and loader paths, letting masters with different data widths and stall behaviour share one memory block without external glue.

## Interface
- ADDR_WIDTH, 10, word address width
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8
- LENGTH, 1<<ADDR_WIDTH, number of words; LENGTH <= 2^ADDR_WIDTH
- BURST_WIDTH, 4, width of burst length field (max 2^BURST_WIDTH beats)

- clk  in  1  clock; all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_write  in  1  1 = write burst, 0 = read burst
- req_addr  in  ADDR_WIDTH  start word address
- req_len  in  BURST_WIDTH  beats minus one
- req_err  out  1  one-cycle pulse: request rejected (bad address)
- wdata  in  DATA_WIDTH  write beat data
- wstrb  in  DATA_WIDTH/8  byte enables, bit i covers wdata[8i+7:8i]
- wvalid  in  1  write beat present
- wready  out  1  write beat accepted this cycle when wvalid also high
- rdata  out  DATA_WIDTH  read beat data
- rvalid  out  1  rdata valid
- rready  in  1  consumer takes rdata
- busy  out  1  burst in progress

## Operation
- States: IDLE, WRITE, READ. req_ready = (state == IDLE); busy = (state != IDLE); wready = (state == WRITE).
- Request handshake: req_valid & req_ready at a rising edge. Latch addr, write flag, beat counter = req_len.
- req_addr >= LENGTH: handshake completes, req_err high for the following cycle, state stays IDLE, no beats, memory untouched.
- WRITE: each wvalid & wready edge writes bytes with wstrb=1 to mem[addr]; bytes with wstrb=0 keep old value. wstrb all-zero is a legal beat (no change, still counts). addr advances, counter decrements; last beat (counter == 0) returns to IDLE.
- READ: a beat issues on each edge where !rvalid | rready: rdata <= mem[addr], rvalid <= 1, addr advances, counter decrements. Last issued beat returns to IDLE. When no beat issues and rready is high, rvalid clears. rdata/rvalid hold stable while rvalid & !rready.
- After the final read beat issues, rvalid may still be pending in IDLE; a new read burst cannot overwrite it (issue condition above still gates).
- Address increment: addr == LENGTH-1 wraps to 0; otherwise addr+1. Counter is BURST_WIDTH bits, no wrap beyond the burst.
- Memory contents are not initialised and are not affected by rst.
- Reset (any time, including mid-burst): state IDLE, rvalid 0, rdata 0, req_err 0, counter 0; remaining beats abandoned. Reset values: req_ready 1, wready 0, busy 0.

## Timing
- Request accepted at edge E0: wready high from the cycle after E0; one write beat per cycle max.
- Read accepted at E0: first beat issues at E1, rvalid high after E1. With rready held high, one beat per cycle, N-beat burst has rvalid for N consecutive cycles.
- Last write beat at edge Ek: req_ready high after Ek; next request may be accepted at Ek+1.
- Write-then-read same address in back-to-back bursts returns the new data (write committed at its beat edge, read issues at least one edge later).
- req_err asserts in the cycle after the rejecting handshake, for exactly one cycle.

## Test plan
- Reset mid-burst: start 8-beat read at 0x010, assert rst after 3 rvalid beats -> rvalid 0, req_ready 1, busy 0 immediately; memory at 0x010..0x017 unchanged.
- Byte strobes: write 0x11223344 at 0x005 (wstrb 4'b1111), then write 0xAABBCCDD with wstrb 4'b0101, read 1 beat -> rdata 0x11BB33DD.
- Wrap: LENGTH=1024, write 4 beats at 0x3FE with data 1,2,3,4; read 4 beats from 0x3FE -> 1,2,3,4 with words at 0x3FE,0x3FF,0x000,0x001.
- Back-pressure: 4-beat read, rready toggles 1,0,0,1,1,0,1 -> each beat presented exactly once, rdata stable while stalled, beats in address order, no beat lost or duplicated.
- Write stall: 3-beat write with wvalid gaps of 2 cycles -> only handshaken beats written, busy high until third beat, req_ready high the cycle after.
- Bad address: LENGTH=768, request at 0x300 -> req_err pulses one cycle, wready never high, state IDLE, subsequent valid request accepted next cycle.
